// File: rtl/cluster_buf_pkg.sv
// Shared defaults and helpers for the cluster ring buffer.
package cluster_buf_pkg;

    localparam int DEF_NUM_CLUSTERS = 8;
    localparam int DEF_ADDR_W       = 2;
    localparam int DEF_HASH_W       = 8;
    localparam int DEF_DEPTH        = 32;
    localparam int DEF_AFULL_LVL    = DEF_DEPTH - 4;
    localparam int DEF_DROP_W       = 16;

    // Pointer width for a power-of-two depth of at least two.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all ones once reached.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc && (value != {WIDTH{1'b1}})) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cluster_ring_buffer.sv
// Ring buffer of cluster bitmaps with in-place head update, retire reporting
// and a saturating counter of rejected pushes.
module cluster_ring_buffer
    import cluster_buf_pkg::*;
#(
    parameter int NUM_CLUSTERS = DEF_NUM_CLUSTERS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int HASH_W       = DEF_HASH_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AFULL_LVL    = DEPTH - 4,
    parameter int DROP_W       = DEF_DROP_W,
    localparam int PTR_W       = ptr_width(DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CLUSTERS-1:0] in_bitmap,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [HASH_W-1:0]       in_hash,
    output logic                    head_valid,
    output logic [NUM_CLUSTERS-1:0] head_bitmap,
    output logic [ADDR_W-1:0]       head_addr,
    output logic [HASH_W-1:0]       head_hash,
    input  logic [NUM_CLUSTERS-1:0] upd_bitmap,
    input  logic                    zero,
    input  logic                    suspect,
    output logic                    retire_valid,
    output logic                    retire_suspect,
    output logic [ADDR_W-1:0]       retire_addr,
    output logic [HASH_W-1:0]       retire_hash,
    output logic [CNT_W-1:0]        count,
    output logic                    almost_full,
    output logic [DROP_W-1:0]       drop_count
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_LVL);

    logic [NUM_CLUSTERS-1:0] bitmap_mem [DEPTH];
    logic [ADDR_W-1:0]       addr_mem   [DEPTH];
    logic [HASH_W-1:0]       hash_mem   [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             pop;
    logic             push;
    logic             drop_inc;

    assign head_valid  = (count != '0);
    assign pop         = head_valid & (zero | suspect);
    assign in_ready    = !flush & ((count < DEPTH_CNT) | pop);
    assign push        = in_valid & in_ready;
    assign drop_inc    = in_valid & !in_ready & !flush;
    assign almost_full = (count >= AFULL_CNT);

    assign head_bitmap = bitmap_mem[head_ptr];
    assign head_addr   = addr_mem[head_ptr];
    assign head_hash   = hash_mem[head_ptr];

    // When full with a pop, tail equals head: the push write below is the only
    // write to that slot because the in-place update is suppressed by the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr       <= '0;
            tail_ptr       <= '0;
            count          <= '0;
            retire_valid   <= 1'b0;
            retire_suspect <= 1'b0;
            retire_addr    <= '0;
            retire_hash    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bitmap_mem[i] <= '0;
                addr_mem[i]   <= '0;
                hash_mem[i]   <= '0;
            end
        end else if (flush) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count        <= '0;
            retire_valid <= 1'b0;
        end else begin
            retire_valid <= pop;
            if (pop) begin
                retire_suspect <= suspect;
                retire_addr    <= addr_mem[head_ptr];
                retire_hash    <= hash_mem[head_ptr];
                head_ptr       <= head_ptr + PTR_W'(1);
            end else if (head_valid) begin
                bitmap_mem[head_ptr] <= upd_bitmap;
            end
            if (push) begin
                bitmap_mem[tail_ptr] <= in_bitmap;
                addr_mem[tail_ptr]   <= in_addr;
                hash_mem[tail_ptr]   <= in_hash;
                tail_ptr             <= tail_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    sat_counter #(
        .WIDTH (DROP_W)
    ) u_drop_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .value (drop_count)
    );

endmodule

// File: tb/tb_cluster_ring_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model; a second instance checks a 2-bit drop counter.
module tb_cluster_ring_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] bitmap;
        logic [1:0] addr;
        logic [7:0] hash;
    } entry_t;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, zero, suspect;
    logic [7:0] in_bitmap, in_hash, upd_bitmap;
    logic [1:0] in_addr;

    logic       in_ready, head_valid, retire_valid, retire_suspect, almost_full;
    logic [7:0] head_bitmap, head_hash, retire_hash;
    logic [1:0] head_addr, retire_addr;
    logic [2:0] count;
    logic [15:0] drop_count;

    logic       s_in_ready, s_head_valid, s_retire_valid, s_retire_suspect, s_almost_full;
    logic [7:0] s_head_bitmap, s_head_hash, s_retire_hash;
    logic [1:0] s_head_addr, s_retire_addr;
    logic [2:0] s_count;
    logic [1:0] s_drop_count;

    entry_t     q[$];
    int         drops;
    logic       m_ret_valid, m_ret_susp;
    logic [1:0] m_ret_addr;
    logic [7:0] m_ret_hash;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cluster_ring_buffer #(
        .NUM_CLUSTERS(8), .ADDR_W(2), .HASH_W(8), .DEPTH(DEPTH), .AFULL_LVL(2), .DROP_W(16)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_bitmap(in_bitmap), .in_addr(in_addr), .in_hash(in_hash),
        .head_valid(head_valid), .head_bitmap(head_bitmap), .head_addr(head_addr),
        .head_hash(head_hash), .upd_bitmap(upd_bitmap), .zero(zero), .suspect(suspect),
        .retire_valid(retire_valid), .retire_suspect(retire_suspect),
        .retire_addr(retire_addr), .retire_hash(retire_hash), .count(count),
        .almost_full(almost_full), .drop_count(drop_count)
    );

    cluster_ring_buffer #(
        .NUM_CLUSTERS(8), .ADDR_W(2), .HASH_W(8), .DEPTH(DEPTH), .AFULL_LVL(2), .DROP_W(2)
    ) dut_small (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_bitmap(in_bitmap), .in_addr(in_addr), .in_hash(in_hash),
        .head_valid(s_head_valid), .head_bitmap(s_head_bitmap), .head_addr(s_head_addr),
        .head_hash(s_head_hash), .upd_bitmap(upd_bitmap), .zero(zero), .suspect(suspect),
        .retire_valid(s_retire_valid), .retire_suspect(s_retire_suspect),
        .retire_addr(s_retire_addr), .retire_hash(s_retire_hash), .count(s_count),
        .almost_full(s_almost_full), .drop_count(s_drop_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs before the edge,
    // advance the model at the edge and check registered outputs afterwards.
    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [7:0] bm, input logic [1:0] ad,
                                 input logic [7:0] hs, input logic [7:0] ub,
                                 input logic z, input logic s);
        logic   hv, p, rdy;
        entry_t e;
        int     sat_small, sat_big;
        reset = r; flush = f; in_valid = iv; in_bitmap = bm; in_addr = ad;
        in_hash = hs; upd_bitmap = ub; zero = z; suspect = s;
        hv  = (q.size() != 0);
        p   = hv && (z || s);
        rdy = !f && ((q.size() < DEPTH) || p);
        #1;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        checkOutput("head_valid_pre", {31'd0, head_valid}, {31'd0, hv});
        if (hv) begin
            checkOutput("head_bitmap", {24'd0, head_bitmap}, {24'd0, q[0].bitmap});
            checkOutput("head_addr", {30'd0, head_addr}, {30'd0, q[0].addr});
            checkOutput("head_hash", {24'd0, head_hash}, {24'd0, q[0].hash});
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            drops = 0;
            m_ret_valid = 1'b0; m_ret_susp = 1'b0; m_ret_addr = '0; m_ret_hash = '0;
        end else if (f) begin
            q.delete();
            m_ret_valid = 1'b0;
        end else begin
            if (iv && !rdy) drops++;
            m_ret_valid = p;
            if (p) begin
                m_ret_susp = s;
                m_ret_addr = q[0].addr;
                m_ret_hash = q[0].hash;
                void'(q.pop_front());
            end else if (hv) begin
                q[0].bitmap = ub;
            end
            if (iv && rdy) begin
                e.bitmap = bm; e.addr = ad; e.hash = hs;
                q.push_back(e);
            end
        end
        @(negedge clk);
        sat_big   = (drops > 65535) ? 65535 : drops;
        sat_small = (drops > 3) ? 3 : drops;
        checkOutput("count", {29'd0, count}, q.size());
        checkOutput("head_valid", {31'd0, head_valid}, {31'd0, (q.size() != 0)});
        checkOutput("almost_full", {31'd0, almost_full}, {31'd0, (q.size() >= 2)});
        checkOutput("retire_valid", {31'd0, retire_valid}, {31'd0, m_ret_valid});
        checkOutput("retire_suspect", {31'd0, retire_suspect}, {31'd0, m_ret_susp});
        checkOutput("retire_addr", {30'd0, retire_addr}, {30'd0, m_ret_addr});
        checkOutput("retire_hash", {24'd0, retire_hash}, {24'd0, m_ret_hash});
        checkOutput("drop_count", {16'd0, drop_count}, sat_big);
        checkOutput("drop_count_w2", {30'd0, s_drop_count}, sat_small);
        checkOutput("count_w2", {29'd0, s_count}, q.size());
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; zero = 1'b0; suspect = 1'b0;
        in_bitmap = '0; in_addr = '0; in_hash = '0; upd_bitmap = '0;
        drops = 0; m_ret_valid = 0; m_ret_susp = 0; m_ret_addr = '0; m_ret_hash = '0;
        @(negedge clk);
        applyStimulus(1, 0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 0, 0);
        #1 checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Fill to DEPTH=4; the head bitmap follows upd_bitmap while it waits.
        applyStimulus(0, 0, 1, 8'h01, 2'd0, 8'h11, 8'h01, 0, 0);
        applyStimulus(0, 0, 1, 8'h02, 2'd1, 8'h22, 8'h01, 0, 0);
        applyStimulus(0, 0, 1, 8'h04, 2'd2, 8'h33, 8'h01, 0, 0);
        applyStimulus(0, 0, 1, 8'h08, 2'd3, 8'h44, 8'h01, 0, 0);
        #1;
        checkOutput("full_count", {29'd0, count}, 32'd4);
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("full_afull", {31'd0, almost_full}, 32'd1);
        checkOutput("full_head_addr", {30'd0, head_addr}, 32'd0);

        // Push and pop together while full.
        applyStimulus(0, 0, 1, 8'hA5, 2'd2, 8'h55, 8'h01, 1, 0);
        #1;
        checkOutput("pp_count", {29'd0, count}, 32'd4);
        checkOutput("pp_retire_valid", {31'd0, retire_valid}, 32'd1);
        checkOutput("pp_retire_hash", {24'd0, retire_hash}, 32'h11);
        checkOutput("pp_head_hash", {24'd0, head_hash}, 32'h22);

        // In-place head update.
        applyStimulus(0, 0, 0, 8'h00, 2'd0, 8'h00, 8'hF0, 0, 0);
        applyStimulus(0, 0, 0, 8'h00, 2'd0, 8'h00, 8'hF0, 0, 0);
        #1;
        checkOutput("upd_bitmap", {24'd0, head_bitmap}, 32'hF0);
        checkOutput("upd_head_hash", {24'd0, head_hash}, 32'h22);
        checkOutput("upd_retire_valid", {31'd0, retire_valid}, 32'd0);

        // Rejected pushes: 3 then 5 total.
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'h77, 2'd1, 8'h66, 8'hF0, 0, 0);
        checkOutput("drop3", {16'd0, drop_count}, 32'd3);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 8'h77, 2'd1, 8'h66, 8'hF0, 0, 0);
        checkOutput("drop5", {16'd0, drop_count}, 32'd5);
        checkOutput("drop5_sat", {30'd0, s_drop_count}, 32'd3);

        // Down to three entries, then flush with push and suspect asserted.
        applyStimulus(0, 0, 0, 8'h00, 2'd0, 8'h00, 8'hF0, 0, 1);
        applyStimulus(0, 1, 1, 8'h99, 2'd3, 8'h99, 8'hF0, 0, 1);
        checkOutput("flush_count", {29'd0, count}, 32'd0);
        checkOutput("flush_retire", {31'd0, retire_valid}, 32'd0);
        checkOutput("flush_drop", {16'd0, drop_count}, 32'd5);

        // Reset mid-stream with two entries.
        applyStimulus(0, 0, 1, 8'h12, 2'd1, 8'hAB, 8'h00, 0, 0);
        applyStimulus(0, 0, 1, 8'h34, 2'd2, 8'hCD, 8'h00, 0, 0);
        applyStimulus(1, 0, 1, 8'h56, 2'd3, 8'hEF, 8'h00, 1, 1);
        checkOutput("rst_count", {29'd0, count}, 32'd0);
        checkOutput("rst_drop", {16'd0, drop_count}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 9) < 6), 8'($urandom), 2'($urandom),
                          8'($urandom), 8'($urandom), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
